// File: rtl/sram_axi_bridge.sv
// Bridges the CPU instruction/data SRAM-style ports onto a single-beat AXI master.
// Define SRAM_AXI_PERF_EN to add the perf_rd_cnt/perf_wr_cnt performance counters.
module sram_axi_bridge (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic        bvalid,
  output logic        bready
`ifdef SRAM_AXI_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt
`endif
);

  typedef enum logic {RD_IDLE, RD_ADDR} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_RESP} wr_state_t;

  rd_state_t rd_state;
  wr_state_t wr_state;

  logic rst_d;
  logic live;
  logic inst_rd_pend;
  logic data_rd_pend;
  logic arvalid_q;
  logic awvalid_q;
  logic wvalid_q;
  logic bready_q;

  logic data_rd_go;
  logic inst_rd_go;
  logic wr_go;
  logic inst_r_hit;
  logic data_r_hit;
  logic b_hit;
  logic aw_done;
  logic w_done;

  // The instruction side is read-only: its write-side inputs are deliberately sunk.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid[3:1]};

  assign arlen   = '0;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awid    = 4'd1;
  assign awlen   = '0;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;

  assign arvalid = arvalid_q & ~reset;
  assign awvalid = awvalid_q & ~reset;
  assign wvalid  = wvalid_q & ~reset;
  assign bready  = bready_q & ~reset;

  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;

  // Requests and completions are masked during reset and the cycle that follows it.
  always_comb begin
    live       = ~reset & ~rst_d;
    data_rd_go = live && rd_state == RD_IDLE && data_sram_req && !data_sram_wr
                 && !data_rd_pend && wr_state == WR_IDLE;
    inst_rd_go = live && rd_state == RD_IDLE && inst_sram_req && !inst_rd_pend && !data_rd_go;
    wr_go      = live && wr_state == WR_IDLE && data_sram_req && data_sram_wr && !data_rd_pend;
    inst_r_hit = live && rvalid && !rid[0] && inst_rd_pend;
    data_r_hit = live && rvalid && rid[0] && data_rd_pend;
    b_hit      = live && wr_state == WR_RESP && bvalid;
    aw_done    = !awvalid_q || awready;
    w_done     = !wvalid_q || wready;

    inst_sram_addr_ok = inst_rd_go;
    data_sram_addr_ok = data_rd_go | wr_go;
    inst_sram_data_ok = inst_r_hit;
    data_sram_data_ok = data_r_hit | b_hit;
  end

  always_ff @(posedge clk) begin
    rst_d <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      arvalid_q    <= 1'b0;
      inst_rd_pend <= 1'b0;
      data_rd_pend <= 1'b0;
      arid         <= '0;
      araddr       <= '0;
      arsize       <= '0;
    end else begin
      if (inst_r_hit) inst_rd_pend <= 1'b0;
      if (data_r_hit) data_rd_pend <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (data_rd_go) begin
            arid         <= 4'd1;
            araddr       <= data_sram_addr;
            arsize       <= {1'b0, data_sram_size};
            arvalid_q    <= 1'b1;
            data_rd_pend <= 1'b1;
            rd_state     <= RD_ADDR;
          end else if (inst_rd_go) begin
            arid         <= 4'd0;
            araddr       <= inst_sram_addr;
            arsize       <= {1'b0, inst_sram_size};
            arvalid_q    <= 1'b1;
            inst_rd_pend <= 1'b1;
            rd_state     <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rd_state  <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state  <= WR_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr    <= '0;
      awsize    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_go) begin
            awaddr    <= data_sram_addr;
            awsize    <= {1'b0, data_sram_size};
            wdata     <= data_sram_wdata;
            wstrb     <= data_sram_wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wr_state  <= WR_SEND;
          end
        end
        WR_SEND: begin
          // AW and W complete independently; leave only once both have handshaken.
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready) wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

`ifdef SRAM_AXI_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else begin
      if (inst_r_hit || data_r_hit) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (b_hit) perf_wr_cnt <= perf_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: directed corner cases, then a randomized AXI slave
// and CPU masters checked against a word-level memory model.
module tb_sram_axi_bridge;

  logic        clk;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, rid, awid, wid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef SRAM_AXI_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt;
`endif

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
`ifdef SRAM_AXI_PERF_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic is_wr; logic [31:0] data;} exp_t;
  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [2:0] size;} ar_t;
  typedef struct packed {logic [31:0] addr; logic [2:0] size; logic [3:0] strb; logic [31:0] data;} aw_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data;} rbeat_t;

  exp_t   inst_exp_q[$];
  exp_t   data_exp_q[$];
  ar_t    ar_exp_q[$];
  aw_t    aw_exp_q[$];
  rbeat_t r_pend[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic rand_en = 1'b0;
  logic issue_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : seed_word(a);
  endfunction

  // Monitor: every data_ok pops the oldest expected response for that port.
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (inst_sram_data_ok) begin
        if (inst_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL inst_data_ok_unexpected: got data_ok=1 expected 0");
        end else begin
          me = inst_exp_q.pop_front();
          check("inst_rdata", inst_sram_rdata, me.data);
          n_rd++;
        end
      end
      if (data_sram_data_ok) begin
        if (data_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL data_data_ok_unexpected: got data_ok=1 expected 0");
        end else begin
          me = data_exp_q.pop_front();
          if (me.is_wr) begin
            check("data_wr_ack_with_bvalid", 32'(bvalid), 32'd1);
            n_wr++;
          end else begin
            check("data_rdata", data_sram_rdata, me.data);
            n_rd++;
          end
        end
      end
    end
  end

  // Randomized CPU masters and AXI slave, active only while rand_en is set.
  logic        inst_acc = 1'b0, data_acc = 1'b0, r_take = 1'b0, b_take = 1'b0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_arm = 1'b0;
  int          b_cnt = 0;
  logic [31:0] got_awaddr, got_wdata;
  logic [2:0]  got_awsize;
  logic [3:0]  got_wstrb;

  initial begin
    ar_t ae;
    aw_t we;
    int k;
    forever begin
      @(negedge clk);
      if (rand_en) begin
        inst_acc = inst_sram_req && inst_sram_addr_ok;
        data_acc = data_sram_req && data_sram_addr_ok;
        if (inst_acc) begin
          inst_exp_q.push_back({1'b0, ref_read(inst_sram_addr)});
          ar_exp_q.push_back({4'd0, inst_sram_addr, 1'b0, inst_sram_size});
        end
        if (data_acc) begin
          if (data_sram_wr) begin
            ref_mem[data_sram_addr] = merge(ref_read(data_sram_addr), data_sram_wdata, data_sram_wstrb);
            data_exp_q.push_back({1'b1, 32'd0});
            aw_exp_q.push_back({data_sram_addr, 1'b0, data_sram_size, data_sram_wstrb, data_sram_wdata});
          end else begin
            data_exp_q.push_back({1'b0, ref_read(data_sram_addr)});
            ar_exp_q.push_back({4'd1, data_sram_addr, 1'b0, data_sram_size});
          end
        end
        if (arvalid && arready) begin
          if (ar_exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL ar_unexpected: got arvalid=1 expected 0");
          end else begin
            ae = ar_exp_q.pop_front();
            check("arid", 32'(arid), 32'(ae.id));
            check("araddr", araddr, ae.addr);
            check("arsize", 32'(arsize), 32'(ae.size));
          end
          r_pend.push_back({arid, slv_read(araddr)});
        end
        r_take = rvalid && rready;
        if (awvalid && awready) begin
          aw_got = 1'b1; got_awaddr = awaddr; got_awsize = awsize;
        end
        if (wvalid && wready) begin
          w_got = 1'b1; got_wdata = wdata; got_wstrb = wstrb;
        end
        if (aw_got && w_got) begin
          if (aw_exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL aw_unexpected: got write to 0x%08h expected none", got_awaddr);
          end else begin
            we = aw_exp_q.pop_front();
            check("awaddr", got_awaddr, we.addr);
            check("awsize", 32'(got_awsize), 32'(we.size));
            check("wstrb", 32'(got_wstrb), 32'(we.strb));
            check("wdata", got_wdata, we.data);
          end
          slv_mem[got_awaddr] = merge(slv_read(got_awaddr), got_wdata, got_wstrb);
          aw_got = 1'b0; w_got = 1'b0;
          b_arm = 1'b1; b_cnt = $urandom_range(0, 3);
        end
        b_take = bvalid && bready;
      end
      @(posedge clk);
      #1;
      if (rand_en) begin
        arready = 1'($urandom_range(0, 1));
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        if (r_take) rvalid = 1'b0;
        if (!rvalid && r_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, r_pend.size() - 1);
          rid = r_pend[k].id;
          rdata = r_pend[k].data;
          rvalid = 1'b1;
          r_pend.delete(k);
        end
        if (b_take) bvalid = 1'b0;
        if (b_arm) begin
          if (b_cnt == 0) begin bvalid = 1'b1; b_arm = 1'b0; end
          else b_cnt--;
        end
        if (inst_acc || !inst_sram_req) begin
          if (issue_en && $urandom_range(0, 1) == 1) begin
            inst_sram_req   = 1'b1;
            inst_sram_wr    = 1'($urandom_range(0, 1));
            inst_sram_size  = 2'd2;
            inst_sram_wstrb = 4'($urandom);
            inst_sram_wdata = $urandom;
            inst_sram_addr  = 32'h1C00_0000 + 32'($urandom_range(0, 63)) * 32'd4;
          end else inst_sram_req = 1'b0;
        end
        if (data_acc || !data_sram_req) begin
          if (issue_en && $urandom_range(0, 1) == 1) begin
            data_sram_req   = 1'b1;
            data_sram_wr    = 1'($urandom_range(0, 1));
            data_sram_size  = 2'($urandom_range(0, 2));
            data_sram_wstrb = 4'($urandom_range(1, 15));
            data_sram_wdata = $urandom;
            data_sram_addr  = 32'($urandom_range(0, 15)) * 32'd4;
          end else data_sram_req = 1'b0;
        end
        inst_acc = 1'b0;
        data_acc = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_wstrb = '0;
    inst_sram_addr = 32'h1C00_0000; inst_sram_wdata = '0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_wstrb = '0;
    data_sram_addr = '0; data_sram_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // Reset state, with an inst request already waiting.
    tick(); smp();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_rready", 32'(rready), 32'd1);
    check("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    check("rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok, data_sram_addr_ok}), 32'd0);
    check("const_ar", {arlen, arburst, arlock, arcache, arprot, 12'd0}, {8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 12'd0});
    check("const_aw", {awid, awlen, awburst, awlock, awcache, awprot, 9'd0},
          {4'd1, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 9'd0});
    check("const_w", 32'({wid, wlast}), 32'({4'd1, 1'b1}));
    tick(); reset = 1'b0;
    smp();
    check("post_rst_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    check("post_rst_arvalid", 32'(arvalid), 32'd0);

    // Lone inst read.
    tick(); smp();
    check("inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    inst_exp_q.push_back({1'b0, 32'h0280_0C05});
    tick(); inst_sram_req = 1'b0;
    smp();
    check("lone_arvalid", 32'(arvalid), 32'd1);
    check("lone_araddr", araddr, 32'h1C00_0000);
    check("lone_arsize", 32'(arsize), 32'd2);
    check("lone_arid", 32'(arid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); smp();
      check("arvalid_hold", 32'(arvalid), 32'd1);
    end
    tick(); arready = 1'b1;
    smp();
    tick(); arready = 1'b0;
    smp();
    check("arvalid_drop", 32'(arvalid), 32'd0);
    tick();
    tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C05;
    smp();
    tick(); rvalid = 1'b0;

    // Simultaneous inst and data reads: data first.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0020; data_sram_size = 2'd2;
    smp();
    check("both_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    check("both_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    data_exp_q.push_back({1'b0, 32'h1111_2222});
    tick(); data_sram_req = 1'b0;
    smp();
    check("both_arid_data", 32'(arid), 32'd1);
    check("both_araddr_data", araddr, 32'h0000_0020);
    check("both_inst_wait", 32'(inst_sram_addr_ok), 32'd0);
    tick(); arready = 1'b1;
    smp();
    tick(); arready = 1'b0;
    smp();
    check("both_inst_addr_ok_next", 32'(inst_sram_addr_ok), 32'd1);
    inst_exp_q.push_back({1'b0, 32'h3333_4444});
    tick(); inst_sram_req = 1'b0;
    smp();
    check("both_arid_inst", 32'(arid), 32'd0);
    check("both_araddr_inst", araddr, 32'h1C00_0040);
    tick(); arready = 1'b1;
    smp();
    tick(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_2222;
    smp();
    tick(); rid = 4'd0; rdata = 32'h3333_4444;
    smp();
    tick(); rvalid = 1'b0;

    // Store, then a load that must wait out the write response.
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0010;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000_DEAD; data_sram_size = 2'd1;
    smp();
    check("st_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    data_exp_q.push_back({1'b1, 32'd0});
    tick(); data_sram_req = 1'b0;
    smp();
    check("st_awvalid", 32'({awvalid, wvalid}), 32'd3);
    check("st_awaddr", awaddr, 32'h0000_0010);
    check("st_awsize", 32'(awsize), 32'd1);
    check("st_wstrb", 32'(wstrb), 32'b0011);
    check("st_wdata", wdata, 32'h0000_DEAD);
    tick(); awready = 1'b1;
    smp();
    tick(); awready = 1'b0;
    smp();
    check("st_aw_done", 32'({awvalid, wvalid}), 32'd1);
    tick(); wready = 1'b1;
    smp();
    tick(); wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0010; data_sram_size = 2'd2;
    smp();
    check("st_resp_valids", 32'({awvalid, wvalid, bready}), 32'd1);
    check("ld_blocked", 32'(data_sram_addr_ok), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); smp();
      check("ld_blocked_wait", 32'({data_sram_addr_ok, data_sram_data_ok}), 32'd0);
    end
    tick(); bvalid = 1'b1;
    smp();
    check("ld_blocked_b_cycle", 32'(data_sram_addr_ok), 32'd0);
    tick(); bvalid = 1'b0;
    smp();
    check("ld_addr_ok_after_b", 32'(data_sram_addr_ok), 32'd1);
    data_exp_q.push_back({1'b0, 32'h0000_BEEF});
    tick(); data_sram_req = 1'b0;
    smp();
    tick(); arready = 1'b1;
    smp();
    tick(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_BEEF;
    smp();
    tick(); rvalid = 1'b0;

    // Reset while arvalid is high; the late beat must be dropped.
    tick(); data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0030;
    smp();
    check("rr_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    tick(); data_sram_req = 1'b0;
    smp();
    check("rr_arvalid", 32'(arvalid), 32'd1);
    tick(); reset = 1'b1;
    smp();
    check("rr_arvalid_in_reset", 32'(arvalid), 32'd0);
    tick(); reset = 1'b0;
    smp();
    check("rr_arvalid_after", 32'(arvalid), 32'd0);
    tick(); rvalid = 1'b1; rid = 4'd1; rdata = 32'h0BAD_0BAD;
    smp();
    check("rr_stray_data_ok", 32'(data_sram_data_ok), 32'd0);
    tick(); rvalid = 1'b0;

    tick(); reset = 1'b1; n_rd = 0; n_wr = 0;
    smp();
    tick(); reset = 1'b0;
    smp();
`ifdef SRAM_AXI_PERF_EN
    check("perf_rd_rst", perf_rd_cnt, 32'd0);
    check("perf_wr_rst", perf_wr_cnt, 32'd0);
`endif
    tick();

    // Randomized traffic, then drain.
    rand_en = 1'b1; issue_en = 1'b1;
    repeat (3000) tick();
    issue_en = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (inst_exp_q.size() == 0 && data_exp_q.size() == 0 && !inst_sram_req && !data_sram_req
          && r_pend.size() == 0 && !rvalid && !bvalid && !b_arm) break;
      tick();
    end
    smp();
    check("drain_inst_q", 32'(inst_exp_q.size()), 32'd0);
    check("drain_data_q", 32'(data_exp_q.size()), 32'd0);
    check("drain_ar_q", 32'(ar_exp_q.size()), 32'd0);
    check("drain_aw_q", 32'(aw_exp_q.size()), 32'd0);
`ifdef SRAM_AXI_PERF_EN
    check("perf_rd_cnt", perf_rd_cnt, 32'(n_rd));
    check("perf_wr_cnt", perf_wr_cnt, 32'(n_wr));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
- REQ-001: The block SHALL have no parameters; all widths are fixed.
- REQ-002: The block SHALL use a single clock and a synchronous, active-high reset, with ports as follows:
  - clk  in  1  sole clock; all state changes on its rising edge.
  - reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- REQ-003: The instruction-side CPU ports SHALL be:
  - inst_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  CPU instruction request.
  - inst_sram_{addr_ok,data_ok}  out  1/1  inst request accepted / inst read data valid.
  - inst_sram_rdata  out  32  instruction read data.
- REQ-004: The data-side CPU ports SHALL be:
  - data_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  CPU data request.
  - data_sram_{addr_ok,data_ok}  out  1/1  data request accepted / read data or write response.
  - data_sram_rdata  out  32  load data.
- REQ-005: The AXI read ports SHALL be:
  - arid/araddr/arsize/arvalid  out  4/32/3/1  read address channel.
  - arready  in  1  read address accepted.
  - rid/rdata/rvalid  in  4/32/1  read data channel.
  - rready  out  1  read data ready.
- REQ-006: The AXI write ports SHALL be:
  - awaddr/awsize/awvalid  out  32/3/1  write address channel.
  - awready  in  1  write address accepted.
  - wdata/wstrb/wvalid  out  32/4/1  write data channel.
  - wready  in  1  write data accepted.
  - bvalid  in  1  write response valid.
  - bready  out  1  write response ready.
- REQ-007: The block SHALL drive the AXI constant outputs as follows: arlen=awlen=0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, awid=4'd1, wid=4'd1, wlast=1.

Function
- REQ-008: arsize and awsize SHALL equal {1'b0, size} of the accepted request; addresses and write data SHALL pass through unmodified.
- REQ-009: The read FSM SHALL have states RD_IDLE and RD_ADDR.
  - In RD_IDLE, it SHALL accept one read, assert addr_ok combinationally in that cycle, latch the request, and enter RD_ADDR.
  - In RD_ADDR, arvalid SHALL be high and held stable until arready; the FSM SHALL then return to RD_IDLE.
- REQ-010: arid SHALL be 0 for instruction reads and 1 for data reads.
- REQ-011: When inst and data reads are both requested in RD_IDLE, the data read SHALL win; inst_sram_addr_ok SHALL be 0 that cycle.
- REQ-012: At most one read per id SHALL be outstanding; a new read for an id SHALL NOT be accepted until its R beat has returned.
- REQ-013: rready SHALL be constantly 1; an R beat SHALL produce a one-cycle data_ok plus rdata on the master selected by rid[0], in the same cycle as rvalid.
- REQ-014: The write FSM SHALL have states WR_IDLE, WR_SEND and WR_RESP.
  - In WR_IDLE, a data_sram write (wr=1) SHALL raise data_sram_addr_ok and move to WR_SEND.
  - In WR_SEND, awvalid and wvalid SHALL both rise; each SHALL drop independently on its own handshake.
  - When both handshakes are done, the FSM SHALL enter WR_RESP with bready=1.
  - On bvalid, the FSM SHALL pulse data_sram_data_ok for one cycle and return to WR_IDLE.
- REQ-015: Hazard rule: a data read SHALL NOT be accepted while the write FSM is not in WR_IDLE, and a write SHALL NOT be accepted while a data read is outstanding.
- REQ-016: An instruction read and a data write SHALL be accepted in the same cycle.
- REQ-017: The block SHALL ignore inst_sram_wr=1 and never write on behalf of the instruction side.
- REQ-018: An inst R beat and bvalid arriving in the same cycle SHALL both complete in that cycle.

Reset
- REQ-019: On reset, both FSMs SHALL return to idle and all outstanding flags SHALL clear; this holds even mid-transaction, and in-flight beats SHALL be dropped.
- REQ-020: During reset and in the cycle after it, arvalid, awvalid, wvalid, bready, all addr_ok and all data_ok SHALL be 0; rready SHALL stay 1.

Configuration
- REQ-021: The macro SRAM_AXI_PERF_EN SHALL control the performance counters.
  - Defined: add outputs perf_rd_cnt[31:0] and perf_wr_cnt[31:0], incremented on each R beat and each B response respectively, zeroed by reset, wrapping from 0xFFFFFFFF to 0.
  - Undefined: these ports and counters SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
- REQ-022: A lone inst read at 0x1C000000, size 2, with arready after 3 cycles and rvalid (rid=0, rdata=0x02800C05) 2 cycles later SHALL yield one inst addr_ok pulse, araddr=0x1C000000, arsize=3'b010, and one inst data_ok with rdata 0x02800C05.
- REQ-023: Inst and data reads requested in the same cycle SHALL give data addr_ok first with arid=1, and inst addr_ok on the following RD_IDLE cycle with arid=0.
- REQ-024: A store to 0x00000010 with wstrb=4'b0011 and data 0xDEAD, with awready before wready and bvalid 4 cycles later, SHALL give one data_data_ok only after bvalid, with wstrb=0011 observed.
- REQ-025: A load issued during WR_RESP SHALL keep data addr_ok at 0 until the cycle after the B pulse.
- REQ-026: Reset asserted in RD_ADDR with arvalid high SHALL give arvalid=0 on the next edge and no data_ok afterwards.
- REQ-027: With SRAM_AXI_PERF_EN defined, 3 reads and 2 writes SHALL give perf_rd_cnt=3 and perf_wr_cnt=2.
